rd_ctrl: RTL and testbench

RD_CTRL -- requirements
Module: rd_ctrl

---
 rtl/rd_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_rd_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rd_ctrl.sv
// Capture-ring record reader: fetches a 16-byte header over Avalon-MM, then streams the payload into a FIFO.
// Optional macro RD_CTRL_HDR_CHECK_EN: reject records whose two header length words differ.
module rd_ctrl #(
  parameter int unsigned BURST_WORDS = 4,
  parameter int unsigned FIFO_DEPTH  = 512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd_req,
  input  logic [31:0] rd_addr,
  input  logic [31:0] capt_buf_start,
  input  logic [31:0] capt_buf_size,
  output logic [31:0] address,
  output logic        read,
  output logic [15:0] burstcount,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  input  logic        readdatavalid,
  output logic [31:0] fifo_in,
  output logic        wr_to_fifo,
  output logic        fifo_last,
  output logic [1:0]  fifo_bytes,
  input  logic [8:0]  usedw,
  output logic [31:0] pkt_seconds,
  output logic [31:0] pkt_nanoseconds,
  output logic [31:0] pkt_len,
  output logic [31:0] next_rd_addr,
  output logic        rd_ctrl_rdy,
  output logic        hdr_err
);

  typedef enum logic [2:0] {
    IDLE = 3'd0, RD_HDR = 3'd1, WAIT_ROOM = 3'd2, RD_DATA = 3'd3, DONE = 3'd4, ERR = 3'd5
  } state_e;

  localparam logic [31:0] BURST_W  = 32'(BURST_WORDS);
  localparam logic [31:0] ROOM_THR = 32'(FIFO_DEPTH - 1 - BURST_WORDS);
  localparam logic [31:0] HDR_W    = 32'd4;

  function automatic logic [31:0] wrap_addr(input logic [31:0] a, input logic [31:0] base,
                                            input logic [31:0] size);
    wrap_addr = (a >= base + size) ? (a - size) : a;
  endfunction

  function automatic logic [31:0] min3(input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] c);
    logic [31:0] m;
    m    = (a < b) ? a : b;
    min3 = (m < c) ? m : c;
  endfunction

  state_e      state_q, state_d;
  logic [31:0] base_q, base_d, size_q, size_d, cur_q, cur_d, rem_q, rem_d;
  logic [15:0] beats_q, beats_d;
  logic [1:0]  hdr_cnt_q, hdr_cnt_d;
  logic        read_q, read_d;
  logic [31:0] address_q, address_d;
  logic [15:0] bc_q, bc_d;
  logic [31:0] fifo_in_q, fifo_in_d;
  logic        wr_q, wr_d, last_q, last_d;
  logic [1:0]  bytes_q, bytes_d;
  logic [31:0] sec_q, sec_d, ns_q, ns_d, len_q, len_d, next_q, next_d;
  logic        rdy_q, rdy_d, err_q, err_d;

  logic        hdr_beat_s, data_beat_s, burst_end_s, hdr_last_s, last_beat_s;
  logic        room_ok_s, issue_s, hdr_mismatch_s;
  logic [31:0] to_end_s, burst_len_s;

  assign hdr_beat_s  = readdatavalid && (state_q == RD_HDR) && (beats_q != 16'd0);
  assign data_beat_s = readdatavalid && (state_q == RD_DATA) && (beats_q != 16'd0);
  assign burst_end_s = (hdr_beat_s || data_beat_s) && (beats_q == 16'd1);
  assign hdr_last_s  = hdr_beat_s && (hdr_cnt_q == 2'd3);
  assign last_beat_s = data_beat_s && (beats_q == 16'd1) && (rem_q == 32'd0);
  assign room_ok_s   = ({23'd0, usedw} <= ROOM_THR);
  assign to_end_s    = (base_q + size_q - cur_q) >> 2;
  assign burst_len_s = min3((state_q == RD_HDR) ? HDR_W : BURST_W, rem_q, to_end_s);
  // A burst is launched only when nothing is outstanding; data bursts launch straight from WAIT_ROOM.
  assign issue_s     = ((state_q == RD_HDR) && !read_q && (beats_q == 16'd0) && (rem_q != 32'd0))
                    || ((state_q == WAIT_ROOM) && room_ok_s);

`ifdef RD_CTRL_HDR_CHECK_EN
  assign hdr_mismatch_s = (readdata != len_q);
`else
  assign hdr_mismatch_s = 1'b0;
`endif

  // State register and all datapath registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;      base_q <= 32'd0;     size_q <= 32'd0;   cur_q <= 32'd0;
      rem_q <= 32'd0;       beats_q <= 16'd0;    hdr_cnt_q <= 2'd0; read_q <= 1'b0;
      address_q <= 32'd0;   bc_q <= 16'd0;       fifo_in_q <= 32'd0; wr_q <= 1'b0;
      last_q <= 1'b0;       bytes_q <= 2'd0;     sec_q <= 32'd0;    ns_q <= 32'd0;
      len_q <= 32'd0;       next_q <= 32'd0;     rdy_q <= 1'b0;     err_q <= 1'b0;
    end else begin
      state_q <= state_d;   base_q <= base_d;    size_q <= size_d;  cur_q <= cur_d;
      rem_q <= rem_d;       beats_q <= beats_d;  hdr_cnt_q <= hdr_cnt_d; read_q <= read_d;
      address_q <= address_d; bc_q <= bc_d;      fifo_in_q <= fifo_in_d; wr_q <= wr_d;
      last_q <= last_d;     bytes_q <= bytes_d;  sec_q <= sec_d;    ns_q <= ns_d;
      len_q <= len_d;       next_q <= next_d;    rdy_q <= rdy_d;    err_q <= err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = rd_req ? RD_HDR : IDLE;
      RD_HDR: begin
        if (hdr_last_s) begin
          if (hdr_mismatch_s)                        state_d = ERR;
          else if (len_q == 32'd0)                   state_d = DONE;
          else if (len_q > size_q - 32'd16)          state_d = ERR;
          else                                       state_d = WAIT_ROOM;
        end else begin
          state_d = RD_HDR;
        end
      end
      WAIT_ROOM: state_d = room_ok_s ? RD_DATA : WAIT_ROOM;
      RD_DATA: begin
        if (burst_end_s) state_d = (rem_q != 32'd0) ? WAIT_ROOM : DONE;
        else             state_d = RD_DATA;
      end
      DONE:      state_d = IDLE;
      ERR:       state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Output and datapath next values.
  always_comb begin
    base_d = base_q;  size_d = size_q;  cur_d = cur_q;  rem_d = rem_q;
    beats_d = beats_q;  hdr_cnt_d = hdr_cnt_q;  address_d = address_q;  bc_d = bc_q;
    fifo_in_d = fifo_in_q;  bytes_d = bytes_q;  sec_d = sec_q;  ns_d = ns_q;  len_d = len_q;
    next_d = next_q;  read_d = read_q;  wr_d = 1'b0;  last_d = 1'b0;

    if (state_q == IDLE && rd_req) begin
      base_d = capt_buf_start;  size_d = capt_buf_size;  cur_d = rd_addr;
      rem_d = HDR_W;  beats_d = 16'd0;  hdr_cnt_d = 2'd0;
    end else if (issue_s) begin
      read_d = 1'b1;  address_d = cur_q;  bc_d = burst_len_s[15:0];  beats_d = burst_len_s[15:0];
      cur_d = wrap_addr(cur_q + (burst_len_s << 2), base_q, size_q);
      rem_d = rem_q - burst_len_s;
    end else if (read_q && !waitrequest) begin
      read_d = 1'b0;
    end else begin
      read_d = read_q;
    end

    if (hdr_beat_s || data_beat_s) beats_d = beats_q - 16'd1;
    else                           hdr_cnt_d = hdr_cnt_d;

    if (hdr_beat_s) begin
      hdr_cnt_d = hdr_cnt_q + 2'd1;
      case (hdr_cnt_q)
        2'd0:    sec_d = readdata;
        2'd1:    ns_d  = readdata;
        2'd2:    len_d = readdata;
        default: rem_d = (len_q + 32'd3) >> 2;
      endcase
    end else begin
      sec_d = sec_q;
    end

    if (data_beat_s) begin
      wr_d = 1'b1;  fifo_in_d = readdata;  last_d = last_beat_s;
      bytes_d = last_beat_s ? len_q[1:0] : 2'd0;
    end else begin
      wr_d = 1'b0;
    end

    rdy_d = (state_q == DONE) || (state_q == ERR);
    if (state_q == DONE) next_d = cur_q;
    else                 next_d = next_q;

    if (state_q == ERR)              err_d = 1'b1;
    else if (state_q == IDLE && rd_req) err_d = 1'b0;
    else                             err_d = err_q;
  end

  assign address = address_q;  assign read = read_q;  assign burstcount = bc_q;
  assign fifo_in = fifo_in_q;  assign wr_to_fifo = wr_q;  assign fifo_last = last_q;
  assign fifo_bytes = bytes_q;  assign pkt_seconds = sec_q;  assign pkt_nanoseconds = ns_q;
  assign pkt_len = len_q;  assign next_rd_addr = next_q;  assign rd_ctrl_rdy = rdy_q;
  assign hdr_err = err_q;

endmodule

// File: tb/tb_rd_ctrl.sv
// Scoreboard bench for rd_ctrl: Avalon slave model over a 4 KiB ring at 0x1000, queued expectations
// for bursts, FIFO words and completion events, checked by independent monitors.
module tb_rd_ctrl;
  logic        clk = 1'b0;
  logic        reset, rd_req, read, waitrequest, readdatavalid, wr_to_fifo, fifo_last;
  logic        rd_ctrl_rdy, hdr_err;
  logic [31:0] rd_addr, capt_buf_start, capt_buf_size, address, readdata, fifo_in;
  logic [31:0] pkt_seconds, pkt_nanoseconds, pkt_len, next_rd_addr;
  logic [15:0] burstcount;
  logic [1:0]  fifo_bytes;
  logic [8:0]  usedw;

  always #5 clk = ~clk;

  rd_ctrl dut (
    .clk(clk), .reset(reset), .rd_req(rd_req), .rd_addr(rd_addr),
    .capt_buf_start(capt_buf_start), .capt_buf_size(capt_buf_size),
    .address(address), .read(read), .burstcount(burstcount), .waitrequest(waitrequest),
    .readdata(readdata), .readdatavalid(readdatavalid), .fifo_in(fifo_in),
    .wr_to_fifo(wr_to_fifo), .fifo_last(fifo_last), .fifo_bytes(fifo_bytes), .usedw(usedw),
    .pkt_seconds(pkt_seconds), .pkt_nanoseconds(pkt_nanoseconds), .pkt_len(pkt_len),
    .next_rd_addr(next_rd_addr), .rd_ctrl_rdy(rd_ctrl_rdy), .hdr_err(hdr_err)
  );

  typedef struct packed { logic [31:0] addr; logic [15:0] cnt; } burst_t;
  typedef struct packed { logic [31:0] data; logic last; logic [1:0] bytes; } fw_t;
  typedef struct packed { logic [31:0] nxt; logic err; } done_t;

  burst_t      exp_bursts[$];
  fw_t         exp_fifo[$];
  done_t       exp_done[$];
  logic [31:0] resp_q[$];
  logic [31:0] mem [0:1023];
  int          checks = 0, failures = 0, stall_cfg = 0;
  logic [31:0] exp_next = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Avalon slave: optional waitrequest stall per burst, beats returned back-to-back after acceptance.
  initial begin
    int          wcnt;
    logic        drop_chk;
    logic [31:0] s_addr, a;
    logic [15:0] s_cnt;
    burst_t      b;
    wcnt = 0; drop_chk = 1'b0; waitrequest = 1'b0; readdatavalid = 1'b0; readdata = 32'd0;
    forever begin
      @(negedge clk);
      if (resp_q.size() > 0) begin readdata = resp_q.pop_front(); readdatavalid = 1'b1; end
      else begin readdata = 32'd0; readdatavalid = 1'b0; end
      if (drop_chk) begin chk("read_drop", {31'd0, read}, 32'd0); drop_chk = 1'b0; end
      if (read) begin
        if (wcnt == 0) begin s_addr = address; s_cnt = burstcount; end
        else begin
          chk("addr_stable", address, s_addr);
          chk("bc_stable", {16'd0, burstcount}, {16'd0, s_cnt});
        end
        if (wcnt < stall_cfg) begin waitrequest = 1'b1; wcnt++; end
        else begin
          waitrequest = 1'b0; wcnt = 0; drop_chk = 1'b1;
          if (exp_bursts.size() == 0) begin
            checks++; failures++;
            $display("FAIL burst_unexp: got 0x%08h/%0d expected none", address, burstcount);
          end else begin
            b = exp_bursts.pop_front();
            chk("burst_addr", address, b.addr);
            chk("burst_cnt", {16'd0, burstcount}, {16'd0, b.cnt});
          end
          for (int i = 0; i < int'(burstcount); i++) begin
            a = address + 32'(i * 4);
            resp_q.push_back(mem[a[11:2]]);
          end
        end
      end else begin
        waitrequest = 1'b0; wcnt = 0;
      end
    end
  end

  // FIFO write monitor.
  initial begin
    fw_t f;
    forever begin
      @(negedge clk);
      if (wr_to_fifo) begin
        if (exp_fifo.size() == 0) begin
          checks++; failures++;
          $display("FAIL fifo_unexp: got 0x%08h expected no write", fifo_in);
        end else begin
          f = exp_fifo.pop_front();
          chk("fifo_data", fifo_in, f.data);
          chk("fifo_last", {31'd0, fifo_last}, {31'd0, f.last});
          if (f.last) chk("fifo_bytes", {30'd0, fifo_bytes}, {30'd0, f.bytes});
        end
      end
    end
  end

  // Completion monitor.
  initial begin
    done_t d;
    logic  prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rd_ctrl_rdy) begin
        chk("rdy_one_cycle", {31'd0, prev}, 32'd0);
        if (exp_done.size() == 0) begin
          checks++; failures++;
          $display("FAIL rdy_unexp: got pulse expected none");
        end else begin
          d = exp_done.pop_front();
          chk("next_rd_addr", next_rd_addr, d.nxt);
          chk("hdr_err", {31'd0, hdr_err}, {31'd0, d.err});
        end
      end
      prev = rd_ctrl_rdy;
    end
  end

  task automatic load_rec(input logic [31:0] a, input logic [31:0] sec, input logic [31:0] ns,
                          input logic [31:0] len, input logic [31:0] w3,
                          input logic [31:0] dbase, input int ndata);
    logic [31:0] p;
    p = a;        mem[p[11:2]] = sec;
    p = a + 32'd4;  mem[p[11:2]] = ns;
    p = a + 32'd8;  mem[p[11:2]] = len;
    p = a + 32'd12; mem[p[11:2]] = w3;
    for (int i = 0; i < ndata; i++) begin
      p = a + 32'd16 + 32'(i * 4);
      mem[p[11:2]] = dbase + 32'(i);
    end
  endtask

  task automatic eb(input logic [31:0] a, input logic [15:0] n);
    exp_bursts.push_back('{addr: a, cnt: n});
  endtask

  task automatic exp_data(input logic [31:0] len, input logic [31:0] dbase);
    int n;
    n = int'((len + 32'd3) >> 2);
    for (int i = 0; i < n; i++)
      exp_fifo.push_back('{data: dbase + 32'(i), last: (i == n - 1), bytes: len[1:0]});
  endtask

  task automatic exp_fin(input logic [31:0] nxt, input logic err);
    exp_done.push_back('{nxt: nxt, err: err});
    if (!err) exp_next = nxt;
  endtask

  task automatic pulse_req(input logic [31:0] a);
    @(negedge clk); rd_addr = a; rd_req = 1'b1;
    @(negedge clk); rd_req = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (exp_done.size() != 0 && k < 2000) begin @(negedge clk); k++; end
    chk({name, "_done"}, 32'(exp_done.size()), 32'd0);
    chk({name, "_bursts_left"}, 32'(exp_bursts.size()), 32'd0);
    chk({name, "_fifo_left"}, 32'(exp_fifo.size()), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_read"}, {31'd0, read}, 32'd0);
    chk({name, "_wr"}, {31'd0, wr_to_fifo}, 32'd0);
    chk({name, "_last"}, {31'd0, fifo_last}, 32'd0);
    chk({name, "_rdy"}, {31'd0, rd_ctrl_rdy}, 32'd0);
    chk({name, "_err"}, {31'd0, hdr_err}, 32'd0);
    chk({name, "_addr"}, address, 32'd0);
    chk({name, "_bc"}, {16'd0, burstcount}, 32'd0);
    chk({name, "_fifo_in"}, fifo_in, 32'd0);
    chk({name, "_bytes"}, {30'd0, fifo_bytes}, 32'd0);
    chk({name, "_sec"}, pkt_seconds, 32'd0);
    chk({name, "_ns"}, pkt_nanoseconds, 32'd0);
    chk({name, "_len"}, pkt_len, 32'd0);
    chk({name, "_next"}, next_rd_addr, 32'd0);
  endtask

  initial begin
    int k, hi;
    reset = 1'b0; rd_req = 1'b0; rd_addr = 32'd0; usedw = 9'd0;
    capt_buf_start = 32'h0000_1000; capt_buf_size = 32'h0000_1000;
    for (int i = 0; i < 1024; i++) mem[i] = 32'hDEAD_0000 + 32'(i);
    repeat (3) @(negedge clk);
    chk_reset_outputs("por");
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // 20-byte record at ring base: ends at 0x1000+16+20.
    load_rec(32'h1000, 32'h11, 32'h22, 32'd20, 32'd20, 32'hA000_0000, 5);
    eb(32'h1000, 16'd4); eb(32'h1010, 16'd4); eb(32'h1020, 16'd1);
    exp_data(32'd20, 32'hA000_0000); exp_fin(32'h1024, 1'b0);
    pulse_req(32'h1000); wait_done("t1");
    chk("t1_sec", pkt_seconds, 32'h11);
    chk("t1_ns", pkt_nanoseconds, 32'h22);
    chk("t1_len", pkt_len, 32'd20);

    // Header straddling the ring end.
    load_rec(32'h1FF8, 32'h33, 32'h44, 32'd6, 32'd6, 32'hB000_0000, 2);
    eb(32'h1FF8, 16'd2); eb(32'h1000, 16'd2); eb(32'h1008, 16'd2);
    exp_data(32'd6, 32'hB000_0000); exp_fin(32'h1010, 1'b0);
    pulse_req(32'h1FF8); wait_done("t2");
    chk("t2_len", pkt_len, 32'd6);

    // Empty record.
    load_rec(32'h1100, 32'h55, 32'h66, 32'd0, 32'd0, 32'd0, 0);
    eb(32'h1100, 16'd4); exp_fin(32'h1110, 1'b0);
    pulse_req(32'h1100); wait_done("t3");

    // FIFO back-pressure and waitrequest stalls.
    stall_cfg = 3; usedw = 9'd510;
    load_rec(32'h1200, 32'h77, 32'h88, 32'd8, 32'd8, 32'hC000_0000, 2);
    eb(32'h1200, 16'd4); eb(32'h1210, 16'd2);
    exp_data(32'd8, 32'hC000_0000); exp_fin(32'h1218, 1'b0);
    pulse_req(32'h1200);
    k = 0;
    while (exp_bursts.size() != 1 && k < 200) begin @(negedge clk); k++; end
    chk("t4_hdr_accept", 32'(exp_bursts.size()), 32'd1);
    repeat (8) @(negedge clk);
    hi = 0;
    repeat (10) begin @(negedge clk); if (read) hi++; end
    chk("t4_hold_510", 32'(hi), 32'd0);
    usedw = 9'd508; hi = 0;
    repeat (6) begin @(negedge clk); if (read) hi++; end
    chk("t4_hold_508", 32'(hi), 32'd0);
    usedw = 9'd507;
    wait_done("t4");
    stall_cfg = 0; usedw = 9'd0;

    // Header length words disagree.
    load_rec(32'h1300, 32'h99, 32'hAA, 32'd8, 32'd9, 32'hE000_0000, 2);
    eb(32'h1300, 16'd4);
`ifdef RD_CTRL_HDR_CHECK_EN
    exp_fin(exp_next, 1'b1);
`else
    eb(32'h1310, 16'd2); exp_data(32'd8, 32'hE000_0000); exp_fin(32'h1318, 1'b0);
`endif
    pulse_req(32'h1300); wait_done("t5");

    // Length one beyond ring capacity minus header.
    load_rec(32'h1500, 32'hBB, 32'hCC, 32'h0000_0FF1, 32'h0000_0FF1, 32'd0, 0);
    eb(32'h1500, 16'd4); exp_fin(exp_next, 1'b1);
    pulse_req(32'h1500); wait_done("t6");
    chk("t6_err_sticky", {31'd0, hdr_err}, 32'd1);

    // Reset on the second data beat.
    load_rec(32'h1400, 32'hDD, 32'hEE, 32'd16, 32'd16, 32'hD000_0000, 4);
    eb(32'h1400, 16'd4); eb(32'h1410, 16'd4);
    exp_fifo.push_back('{data: 32'hD000_0000, last: 1'b0, bytes: 2'd0});
    pulse_req(32'h1400);
    chk("t7_err_clr", {31'd0, hdr_err}, 32'd0);
    k = 0;
    while (!wr_to_fifo && k < 300) begin @(negedge clk); k++; end
    chk("t7_first_beat", {31'd0, wr_to_fifo}, 32'd1);
    reset = 1'b0;
    @(negedge clk);
    chk_reset_outputs("t7_rst");
    reset = 1'b1;
    @(negedge clk);
    chk("t7_no_wr_after_rst", {31'd0, wr_to_fifo}, 32'd0);
    chk("t7_fifo_left", 32'(exp_fifo.size()), 32'd0);
    exp_bursts.delete(); exp_fifo.delete(); exp_done.delete(); exp_next = 32'd0;
    k = 0;
    while (resp_q.size() != 0 && k < 50) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);

    // New request accepted after the reset.
    load_rec(32'h1000, 32'h11, 32'h22, 32'd20, 32'd20, 32'hA100_0000, 5);
    eb(32'h1000, 16'd4); eb(32'h1010, 16'd4); eb(32'h1020, 16'd1);
    exp_data(32'd20, 32'hA100_0000); exp_fin(32'h1024, 1'b0);
    pulse_req(32'h1000); wait_done("t8");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
